mem_responder: RTL



---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: access size codes, FSM encodings,
// core opcodes and the size/alignment legality check.
package mem_pkg;

  localparam logic [2:0] SZ_B  = 3'h0;
  localparam logic [2:0] SZ_H  = 3'h1;
  localparam logic [2:0] SZ_W  = 3'h2;
  localparam logic [2:0] SZ_BU = 3'h4;
  localparam logic [2:0] SZ_HU = 3'h5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Range checking depends on the array depth, so it lives in the responder.
  function automatic logic access_err(input logic write, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad_size;
    logic misaligned;
    if (write) bad_size = !(funct3 inside {SZ_B, SZ_H, SZ_W});
    else       bad_size = !(funct3 inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
    misaligned = ((funct3 == SZ_H || funct3 == SZ_HU) && addr_lo[0]) ||
                 (funct3 == SZ_W && addr_lo != 2'b00);
    return bad_size || misaligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte-enables and replicated write word, plus
// sign/zero-extended load data extracted from the addressed word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = rd_word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[addr_lo];
  assign sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_en   = 4'b0000;
    wr_word   = wdata;
    load_data = 32'h0;
    case (funct3)
      SZ_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wr_word   = {4{wdata[7:0]}};
        load_data = {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{wdata[15:0]}};
        load_data = {{16{sel_half[15]}}, sel_half};
      end
      SZ_W: begin
        byte_en   = 4'b1111;
        load_data = rd_word;
      end
      SZ_BU:   load_data = {24'h0, sel_byte};
      SZ_HU:   load_data = {16'h0, sel_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the multicycle core: accepts one
// fetch/load/store, waits WAIT_CYCLES, commits, and returns a one-cycle response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, wdata_reg;
  logic [2:0]  funct3_reg;
  logic        write_reg;
  logic        resp_valid_reg, resp_err_reg;
  logic [31:0] resp_rdata_reg;

  logic        accept, commit, err, wr_en;
  logic [31:0] cur_addr, cur_wdata, rd_word, wr_word, load_data;
  logic [2:0]  cur_funct3;
  logic        cur_write;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]  byte_en;

  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait the commit happens on the accept edge, so use the live inputs.
  assign cur_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign cur_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign cur_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
  assign cur_write  = (state_reg == IDLE) ? req_write  : write_reg;
  assign cur_idx    = cur_addr[IDX_W+1:2];

  assign commit = ((state_reg == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                  ((state_reg == WAIT) && (cnt_reg == 4'd0));
  assign err    = access_err(cur_write, cur_funct3, cur_addr[1:0]) ||
                  (cur_addr[31:2] >= 30'(DEPTH_WORDS));
  assign wr_en  = commit && !rst && cur_write && !err;

  assign rd_word = mem[cur_idx];

  mem_lane_align u_align (
    .addr_lo   (cur_addr[1:0]),
    .funct3    (cur_funct3),
    .rd_word   (rd_word),
    .wdata     (cur_wdata),
    .byte_en   (byte_en),
    .wr_word   (wr_word),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[cur_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      funct3_reg     <= 3'h0;
      write_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        funct3_reg <= req_funct3;
        write_reg  <= req_write;
      end
      resp_valid_reg <= commit;
      resp_err_reg   <= commit && err;
      resp_rdata_reg <= (commit && !err && !cur_write) ? load_data : 32'h0;
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule
